// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit on the requester side of the instruction ROM.
// It owns the PC and drives the ROM enable and word address. The ROM returns the
// instruction in the same cycle, and this unit registers it with its PC into a
// single-entry output stage that hands off to decode under valid/ready.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rom_ce, rom_addr           ROM enable (combinational) and word address
//   rom_inst                   ROM data, same cycle as the address
//   out_valid/out_ready        handshake of the output stage
//   out_pc, out_inst           PC and instruction held in the output stage
//   redirect_valid/redirect_pc branch redirect pulse and byte target
//   halt_req, halted           halt request level and halt-state flag
//   misalign_err               one-cycle pulse after a misaligned redirect target
//   fetch_cnt                  count of completed handoffs, wraps at 2^32
module ifu_fetch #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       ROM_AW   = 6,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h0000_0000_8000_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_ce,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              halted,
  output logic              misalign_err,
  output logic [31:0]       fetch_cnt
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_pc_q, out_pc_d;
  logic [INST_W-1:0]   out_inst_q, out_inst_d;
  logic                misalign_q, misalign_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                halted_q, halted_d;

  logic                fire_slot;
  logic                handoff;
  logic                redir_take;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      misalign_q  <= 1'b0;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      misalign_q  <= misalign_d;
      cnt_q       <= cnt_d;
      halted_q    <= halted_d;
    end
  end

  // Next-state, fetch/redirect datapath and ROM enable.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    misalign_d  = 1'b0;
    cnt_d       = cnt_q;

    fire_slot  = !out_valid_q || out_ready;
    handoff    = out_valid_q && out_ready;
    // Redirects are ignored during the boot cycle.
    redir_take = redirect_valid && (state_q != ST_BOOT);
    // A redirect squashes this cycle's fetch, so the ROM is not enabled.
    rom_ce     = (state_q == ST_RUN) && fire_slot && !redir_take;

    if (handoff) begin
      cnt_d       = cnt_q + CNT_W'(1);
      out_valid_d = 1'b0;
    end

    // A fetch refills the stage, possibly in the same cycle as a handoff.
    if (rom_ce) begin
      out_valid_d = 1'b1;
      out_pc_d    = pc_q;
      out_inst_d  = rom_inst;
      pc_d        = pc_q + ADDR_W'(4);
    end

    if (redir_take) begin
      pc_d        = {redirect_pc[ADDR_W-1:2], 2'b00};
      out_valid_d = 1'b0;
      misalign_d  = |redirect_pc[1:0];
    end

    unique case (state_q)
      ST_BOOT: state_d = halt_req ? ST_HALT : ST_RUN;
      ST_RUN:  if (halt_req) state_d = ST_HALT;
      ST_HALT: if (redirect_valid && !halt_req) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    halted_d = (state_d == ST_HALT);
  end

  assign rom_addr     = pc_q[ROM_AW+1:2];
  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_inst     = out_inst_q;
  assign misalign_err = misalign_q;
  assign fetch_cnt    = cnt_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a ROM array, a transaction-level model of the fetch unit
// checked every cycle, and directed scenarios with literal expectations.
module tb_ifu_fetch;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned INST_W = 32;
  localparam int unsigned ROM_AW = 6;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rom_ce;
  logic [ROM_AW-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              halt_req = 1'b0;
  logic              halted;
  logic              misalign_err;
  logic [31:0]       fetch_cnt;

  logic [31:0] rom [64];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rom_inst = rom_ce ? rom[rom_addr] : 32'h0;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted),
    .misalign_err(misalign_err), .fetch_cnt(fetch_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = boot cycle, 1 = fetching, 2 = halted.
  int          m_mode = 0;
  logic [63:0] m_pc   = RST_PC;
  logic        m_v    = 1'b0;
  logic [63:0] m_opc  = '0;
  logic [31:0] m_oinst = '0;
  logic [31:0] m_cnt  = '0;
  logic        m_mis  = 1'b0;

  function automatic logic exp_ce();
    return (m_mode == 1) && (!m_v || out_ready) && !redirect_valid;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_pc    <= RST_PC;
      m_v     <= 1'b0;
      m_opc   <= '0;
      m_oinst <= '0;
      m_cnt   <= '0;
      m_mis   <= 1'b0;
    end else begin
      logic took;
      took = m_v && out_ready;
      m_cnt <= m_cnt + (took ? 32'd1 : 32'd0);
      m_mis <= 1'b0;
      if (m_mode == 0) begin
        m_mode <= halt_req ? 2 : 1;
        if (took) m_v <= 1'b0;
      end else if (redirect_valid) begin
        m_pc   <= redirect_pc & ~64'd3;
        m_v    <= 1'b0;
        m_mis  <= (redirect_pc[1:0] != 2'b00);
        m_mode <= halt_req ? 2 : 1;
      end else begin
        if (exp_ce()) begin
          m_opc   <= m_pc;
          m_oinst <= rom[m_pc[7:2]];
          m_v     <= 1'b1;
          m_pc    <= m_pc + 64'd4;
        end else if (took) begin
          m_v <= 1'b0;
        end
        if (m_mode == 1 && halt_req) m_mode <= 2;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("valid", 64'(out_valid), 64'(m_v));
    check("rom_ce", 64'(rom_ce), 64'(exp_ce()));
    check("rom_addr", 64'(rom_addr), 64'(m_pc[7:2]));
    check("halted", 64'(halted), 64'(m_mode == 2));
    check("misalign", 64'(misalign_err), 64'(m_mis));
    check("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
    if (m_v) begin
      check("out_pc", out_pc, m_opc);
      check("out_inst", 64'(out_inst), 64'(m_oinst));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + 32'(i);
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;

    // Reset state
    step(); step(); mid();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc", out_pc, 64'd0);
    check("rst_inst", 64'(out_inst), 64'd0);
    check("rst_cnt", 64'(fetch_cnt), 64'd0);
    check("rst_addr", 64'(rom_addr), 64'd0);

    // 1: streaming fetch
    step(); rst_n = 1'b1; mid();
    check("t1_boot_ce", 64'(rom_ce), 64'd0);
    step(); mid();
    check("t1_ce", 64'(rom_ce), 64'd1);
    step(); mid();
    check("t1_pc0", out_pc, 64'h8000_0000);
    check("t1_i0", 64'(out_inst), 64'h11);
    step(); mid();
    check("t1_pc1", out_pc, 64'h8000_0004);
    check("t1_i1", 64'(out_inst), 64'h22);
    step(); mid();
    check("t1_pc2", out_pc, 64'h8000_0008);
    check("t1_i2", 64'(out_inst), 64'h33);
    step(); mid();
    check("t1_cnt", 64'(fetch_cnt), 64'd3);

    // 3: aligned redirect while valid
    step(); redirect_valid = 1'b1; redirect_pc = 64'h8000_0020; mid();
    check("t3_ce", 64'(rom_ce), 64'd0);
    step(); redirect_valid = 1'b0; mid();
    check("t3_flush", 64'(out_valid), 64'd0);
    step(); mid();
    check("t3_pc", out_pc, 64'h8000_0020);
    check("t3_inst", 64'(out_inst), 64'hA000_0008);

    // 4: misaligned redirect
    step(); redirect_valid = 1'b1; redirect_pc = 64'h8000_0013;
    step(); redirect_valid = 1'b0; mid();
    check("t4_mis", 64'(misalign_err), 64'd1);
    step(); mid();
    check("t4_mis_off", 64'(misalign_err), 64'd0);
    check("t4_pc", out_pc, 64'h8000_0010);
    check("t4_inst", 64'(out_inst), 64'hA000_0004);

    // 5: halt and resume via redirect
    step(); halt_req = 1'b1;
    step(); mid();
    check("t5_halted", 64'(halted), 64'd1);
    check("t5_ce", 64'(rom_ce), 64'd0);
    step(); mid();
    check("t5_drain", 64'(out_valid), 64'd0);
    step(); halt_req = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0000; mid();
    check("t5_still", 64'(halted), 64'd1);
    step(); redirect_valid = 1'b0; mid();
    check("t5_run", 64'(halted), 64'd0);
    check("t5_ce_on", 64'(rom_ce), 64'd1);
    step(); mid();
    check("t5_pc", out_pc, 64'h8000_0000);
    check("t5_inst", 64'(out_inst), 64'h11);

    // 6: asynchronous reset mid-stream
    step(); mid();
    check("t6_pre", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_addr", 64'(rom_addr), 64'd0);
    check("t6_cnt", 64'(fetch_cnt), 64'd0);

    // 2: backpressure after the first fetch
    step(); rst_n = 1'b1;
    step();
    step(); out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mid();
      check("t2_inst", 64'(out_inst), 64'h11);
      check("t2_ce", 64'(rom_ce), 64'd0);
      check("t2_addr", 64'(rom_addr), 64'd1);
      if (k < 3) step();
    end
    step(); out_ready = 1'b1;
    step(); mid();
    check("t2_next", 64'(out_inst), 64'h22);
    check("t2_next_pc", out_pc, 64'h8000_0004);

    // Mixed traffic tail, checked by the model only
    for (int c = 0; c < 300; c++) begin
      step();
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 64'h8000_0000 + 64'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) halt_req = ~halt_req;
    end
    step(); redirect_valid = 1'b0; halt_req = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
